// File: rtl/simple_dual_port_ram_pkg.sv
// Generic helpers shared by the storage primitives.
package simple_dual_port_ram_pkg;

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: synchronous write port, zero-latency combinational
// read port. Asynchronous active-high reset clears every word.
module simple_dual_port_ram
  import simple_dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic [$clog2(MEM_DEPTH)-1:0]  write_addr,
  input  logic [$clog2(MEM_DEPTH)-1:0]  read_addr,
  output logic [DATA_WIDTH-1:0]         read_data
);

  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  // One extra bit so the depth itself is representable for range compares.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  if (MEM_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "simple_dual_port_ram: MEM_DEPTH must be >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "simple_dual_port_ram: DATA_WIDTH must be >= 1");
  end
  if (!is_pow2(MEM_DEPTH)) begin : g_non_pow2
    $warning("simple_dual_port_ram: MEM_DEPTH is not a power of 2; high addresses are unused");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  write_in_range;
  logic                  read_in_range;

  assign write_in_range = ({1'b0, write_addr} < DEPTH_L);
  assign read_in_range  = ({1'b0, read_addr} < DEPTH_L);

  // Storage: reset wipes all words at once; otherwise store on enabled, in-range writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write && write_in_range) begin
      mem[write_addr] <= write_data;
    end
  end

  // Read path: no bypass, so a same-address write shows only after its edge.
  always_comb begin
    read_data = '0;
    if (read_in_range) begin
      read_data = mem[read_addr];
    end
  end

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed self-checking bench for simple_dual_port_ram (16 x 8).
module tb_simple_dual_port_ram;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [DW-1:0] write_data;
  logic [AW-1:0] write_addr;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;

  int checks   = 0;
  int failures = 0;

  simple_dual_port_ram #(.DATA_WIDTH(DW), .MEM_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .write_data (write_data),
    .write_addr (write_addr),
    .read_addr  (read_addr),
    .read_data  (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_addr = a;
    write_data = d;
    write      = 1'b1;
    @(posedge clk);
    #1;
    write      = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    write      = 1'b0;
    write_data = '0;
    write_addr = '0;
    read_addr  = '0;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset contents
    for (int a = 0; a < 16; a++) begin
      read_addr = AW'(a);
      #1;
      check($sformatf("reset_mem[%0d]", a), read_data, 8'h00);
    end

    // Write then read, zero-latency read
    wr(4'd3, 8'hA5);
    read_addr = 4'd3;
    #1;
    check("read_addr3", read_data, 8'hA5);
    read_addr = 4'd4;
    #1;
    check("read_addr4", read_data, 8'h00);

    // Same-address read during write
    wr(4'd5, 8'h11);
    read_addr  = 4'd5;
    write_addr = 4'd5;
    write_data = 8'h22;
    write      = 1'b1;
    #1;
    check("rdw_before_edge", read_data, 8'h11);
    @(posedge clk);
    #1;
    write = 1'b0;
    check("rdw_after_edge", read_data, 8'h22);

    // Write enable low
    write_addr = 4'd7;
    write_data = 8'hFF;
    write      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_addr = 4'd7;
    #1;
    check("write_low_addr7", read_data, 8'h00);

    // Fill with addr ^ 0x5A
    for (int a = 0; a < 16; a++) wr(AW'(a), DW'(a ^ 8'h5A));
    read_addr = 4'd0;
    #1;
    check("fill_addr0", read_data, 8'h5A);
    read_addr = 4'd15;
    #1;
    check("fill_addr15", read_data, 8'h55);

    // Async reset between edges; write during reset is dropped
    #1;
    rst = 1'b1;
    #1;
    for (int a = 0; a < 16; a++) begin
      read_addr = AW'(a);
      #0;
      check($sformatf("async_rst[%0d]", a), read_data, 8'h00);
    end
    write_addr = 4'd9;
    write_data = 8'h77;
    write      = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    read_addr = 4'd9;
    #1;
    check("write_in_reset_rst_high", read_data, 8'h00);
    rst = 1'b0;
    #1;
    check("write_in_reset_after", read_data, 8'h00);
    @(posedge clk);
    #1;

    // Full sweep with independent ports
    for (int a = 0; a < 16; a++) begin
      write_addr = AW'(a);
      write_data = DW'(8'hF0 + a);
      write      = 1'b1;
      read_addr  = AW'(a - 1);
      #1;
      if (a == 0) check("sweep_prev[15]", read_data, 8'h00);
      else check($sformatf("sweep_prev[%0d]", a - 1), read_data, DW'(8'hF0 + a - 1));
      @(posedge clk);
      #1;
    end
    write = 1'b0;
    for (int a = 0; a < 16; a++) begin
      read_addr = AW'(a);
      #1;
      check($sformatf("final[%0d]", a), read_data, DW'(8'hF0 + a));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_dual_port_ram.md
Name: simple_dual_port_ram

Overview:
- Simple dual-port RAM: one synchronous write port and one asynchronous (combinational) read port, sharing one clock domain.
- It is the storage element beneath the team's FIFO.
- The FIFO drives the write port from its write pointer and the read port from its read pointer.
- The FIFO presents read_data directly as its read-side payload in the same cycle the pointer points at it, so the read path has zero latency.

Parameters:
- DATA_WIDTH, default 8, width of each stored word in bits; must be ≥1.
- MEM_DEPTH, default 16, number of words; must be ≥2. Power of 2 is recommended, not required.
- ADDR_WIDTH (localparam), $clog2(MEM_DEPTH), address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset.
- write  input  1  write enable, sampled on rising clk.
- write_data  input  DATA_WIDTH  word to store.
- write_addr  input  ADDR_WIDTH  write address.
- read_addr  input  ADDR_WIDTH  read address.
- read_data  output  DATA_WIDTH  word at read_addr, combinational.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Storage: array of MEM_DEPTH words × DATA_WIDTH bits.
- Reset:
  - rst=1 clears every word to 0 immediately, without waiting for a clock edge.
  - While rst=1, writes are ignored and read_data=0 for any address.
  - Reset asserted mid-operation discards all contents. Any write on the same edge as rst is lost.
- Write:
  - On rising clk with rst=0 and write=1, mem[write_addr] <= write_data.
  - write=0 leaves memory unchanged. Write latency is 1 cycle.
- Read:
  - read_data = mem[read_addr] continuously; no clock and no enable.
  - Changing read_addr updates read_data in the same cycle.
- Read-during-write to the same address:
  - Before the clock edge, read_data shows the old contents.
  - After the edge, it shows write_data.
  - There is no write-to-read bypass within the cycle.
- Out-of-range addresses (address ≥ MEM_DEPTH, only possible when MEM_DEPTH is not a power of 2):
  - Writes are dropped.
  - read_data=0.
- Wrap-around: none internal; addresses are used as given. Pointer wrap is the caller's responsibility.
- No X propagation after reset: every word has a defined value.
- Elaboration check: MEM_DEPTH<2 or DATA_WIDTH<1 triggers $fatal.

Decomposition:
- No new typedefs.
- ADDR_WIDTH is derived locally.
- Parameter checks may reuse the existing generic function package helpers, e.g. is_pow2 if a power-of-2 warning is desired. No new package content is needed.
- Single module, no sub-modules.

Test Plan:
- Reset contents: assert rst with MEM_DEPTH=16, DATA_WIDTH=8, then deassert; sweep read_addr 0..15 -> read_data=0x00 at every address.
- Write then read:
  - write=1, write_addr=3, write_data=0xA5, one clock; then read_addr=3 -> read_data=0xA5 in the same cycle the address is applied.
  - read_addr=4 -> 0x00.
- Same-address read-during-write:
  - mem[5]=0x11; read_addr=5, write_addr=5, write_data=0x22, write=1.
  - read_data=0x11 before the edge, 0x22 after the edge.
- Write enable low: write=0, write_addr=7, write_data=0xFF for 3 clocks -> read_addr=7 reads 0x00.
- Async reset mid-operation:
  - Fill all 16 words with addr^0x5A.
  - Pulse rst between clock edges -> read_data=0 immediately for all addresses.
  - A write=1 on the edge while rst=1 is not stored.
- Full sweep / independent ports:
  - Write addresses 0..15 with values 0xF0+addr while reading read_addr=addr-1.
  - Each read returns the previously written value.
  - Final sweep matches 0xF0..0xFF.
